// File: rtl/pll_bringup_sequencer.sv
// rtl/pll_bringup_sequencer.sv - PLL reset/lock bring-up sequencer with retry, fault and loss supervision
module pll_bringup_sequencer #(
  parameter int NUM_PLLS      = 3,
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_ATTEMPTS  = 4,
  localparam int IW = (NUM_PLLS > 1) ? $clog2(NUM_PLLS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_PLLS-1:0] pll_lock_async,
  input  logic                restart,
  output logic [NUM_PLLS-1:0] pll_rst,
  output logic [NUM_PLLS-1:0] pll_ready,
  output logic                all_ready,
  output logic                fault,
  output logic [IW-1:0]       fault_idx,
  output logic [7:0]          loss_count
);

  localparam int MAXC_A = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int MAXC   = (MAXC_A > STABLE_CYCLES) ? MAXC_A : STABLE_CYCLES;
  localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int AW     = (MAX_ATTEMPTS > 1) ? $clog2(MAX_ATTEMPTS) : 1;

  localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] ST_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [AW-1:0] ATT_LAST = AW'(MAX_ATTEMPTS - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_PLLS - 1);

  typedef enum logic [2:0] {
    S_RESET,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t              state, state_nxt;
  logic [IW-1:0]       idx, idx_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [AW-1:0]       attempts, attempts_nxt;
  logic [NUM_PLLS-1:0] lock_meta, lock_s;
  logic [NUM_PLLS-1:0] ready_nxt, rst_nxt;
  logic                fault_nxt;
  logic [IW-1:0]       fault_idx_nxt, low_idx;
  logic [7:0]          loss_nxt;
  logic                any_low, fail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta  <= '0;
      lock_s     <= '0;
      state      <= S_RESET;
      idx        <= '0;
      cnt        <= '0;
      attempts   <= '0;
      pll_rst    <= '1;
      pll_ready  <= '0;
      all_ready  <= 1'b0;
      fault      <= 1'b0;
      fault_idx  <= '0;
      loss_count <= '0;
    end else begin
      lock_meta  <= pll_lock_async;
      lock_s     <= lock_meta;
      state      <= state_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      attempts   <= attempts_nxt;
      pll_rst    <= rst_nxt;
      pll_ready  <= ready_nxt;
      all_ready  <= (state_nxt == S_RUN);
      fault      <= fault_nxt;
      fault_idx  <= fault_idx_nxt;
      loss_count <= loss_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    cnt_nxt       = cnt;
    attempts_nxt  = attempts;
    ready_nxt     = pll_ready;
    fault_nxt     = fault;
    fault_idx_nxt = fault_idx;
    loss_nxt      = loss_count;
    fail          = 1'b0;
    any_low       = 1'b0;
    low_idx       = '0;
    rst_nxt       = '0;

    // Descending scan so the lowest unlocked PLL wins.
    for (int k = NUM_PLLS - 1; k >= 0; k--) begin
      if (!lock_s[k]) begin
        any_low = 1'b1;
        low_idx = IW'(k);
      end
    end

    case (state)
      S_RESET: begin
        if (cnt == RST_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_WAIT_LOCK;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s[idx]) begin
          cnt_nxt   = '0;
          state_nxt = S_STABLE;
        end else if (cnt == TO_LAST) begin
          fail = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_STABLE: begin
        if (!lock_s[idx]) begin
          fail = 1'b1;
        end else if (cnt == ST_LAST) begin
          ready_nxt[idx] = 1'b1;
          attempts_nxt   = '0;
          cnt_nxt        = '0;
          if (idx == IDX_LAST) begin
            state_nxt = S_RUN;
          end else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = S_RESET;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (any_low) begin
          if (loss_count != 8'hFF) loss_nxt = loss_count + 8'd1;
          for (int k = 0; k < NUM_PLLS; k++) begin
            if (IW'(k) >= low_idx) ready_nxt[k] = 1'b0;
          end
          idx_nxt      = low_idx;
          attempts_nxt = '0;
          cnt_nxt      = '0;
          state_nxt    = S_RESET;
        end
      end
      S_FAULT: begin
        state_nxt = S_FAULT;
      end
      default: begin
        state_nxt = S_RESET;
      end
    endcase

    if (fail) begin
      if (attempts == ATT_LAST) begin
        state_nxt     = S_FAULT;
        fault_nxt     = 1'b1;
        fault_idx_nxt = idx;
      end else begin
        attempts_nxt = attempts + 1'b1;
        cnt_nxt      = '0;
        state_nxt    = S_RESET;
      end
    end

    if (restart) begin
      state_nxt     = S_RESET;
      idx_nxt       = '0;
      cnt_nxt       = '0;
      attempts_nxt  = '0;
      ready_nxt     = '0;
      fault_nxt     = 1'b0;
      fault_idx_nxt = '0;
    end

    // PLLs above the active index stay in reset; the active one only while resetting or faulted.
    for (int k = 0; k < NUM_PLLS; k++) begin
      rst_nxt[k] = (IW'(k) > idx_nxt) ||
                   ((IW'(k) == idx_nxt) && ((state_nxt == S_RESET) || (state_nxt == S_FAULT)));
    end
  end

endmodule

// File: tb/tb_pll_bringup_sequencer.sv
// tb/tb_pll_bringup_sequencer.sv - scenario bench for pll_bringup_sequencer with a behavioural PLL lock model
module tb_pll_bringup_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] pll_lock_async;
  logic       restart;
  logic [2:0] pll_rst;
  logic [2:0] pll_ready;
  logic       all_ready;
  logic       fault;
  logic [1:0] fault_idx;
  logic [7:0] loss_count;

  logic [2:0] stuck, drop, glitch;
  int         mcnt [3];
  int         pass_cnt = 0;
  int         total_cnt = 0;
  int         exp_loss = 0;
  logic [2:0] exp_q [$];

  pll_bringup_sequencer #(
    .NUM_PLLS(3), .RESET_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .MAX_ATTEMPTS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock_async(pll_lock_async), .restart(restart),
    .pll_rst(pll_rst), .pll_ready(pll_ready), .all_ready(all_ready), .fault(fault),
    .fault_idx(fault_idx), .loss_count(loss_count)
  );

  always #5 clk = ~clk;

  // Lock rises 5 cycles after a PLL leaves reset; stuck/drop/glitch shape faults.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (pll_rst[i]) mcnt[i] = 0;
      else if (mcnt[i] < 100000) mcnt[i] = mcnt[i] + 1;
    end
  end

  always_comb begin
    pll_lock_async = '0;
    for (int i = 0; i < 3; i++)
      pll_lock_async[i] = !pll_rst[i] && (mcnt[i] >= 5) && !stuck[i] && !drop[i] &&
                          !(glitch[i] && (mcnt[i] == 9));
  end

  task automatic run_length(input int k, input logic lvl, output int n);
    n = 0;
    while (pll_rst[k] === lvl && n < 3000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_rst_level(input int k, input logic lvl, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (pll_rst[k] === lvl) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_all_ready(input logic lvl, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (all_ready === lvl) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_ready_change(input logic [2:0] prev, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (pll_ready !== prev) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; restart = 1'b0; stuck = '0; drop = '0; glitch = '0;
    repeat (3) @(negedge clk);
    total_cnt++; if (pll_rst !== 3'b111) $display("FAIL reset_pll_rst got=%b exp=111", pll_rst); else pass_cnt++;
    total_cnt++; if (pll_ready !== 3'b000) $display("FAIL reset_pll_ready got=%b exp=000", pll_ready); else pass_cnt++;
    total_cnt++; if (all_ready !== 1'b0) $display("FAIL reset_all_ready got=%b exp=0", all_ready); else pass_cnt++;
    total_cnt++; if (fault !== 1'b0 || fault_idx !== 2'd0) $display("FAIL reset_fault got=%b/%0d exp=0/0", fault, fault_idx); else pass_cnt++;
    total_cnt++; if (loss_count !== 8'd0) $display("FAIL reset_loss_count got=%0d exp=0", loss_count); else pass_cnt++;
    rst_n = 1'b1;
    run_length(0, 1'b1, n);
    total_cnt++; if (n != 4) $display("FAIL reset_pll0_pulse got=%0d exp=4", n); else pass_cnt++;
  endtask

  task automatic test_normal_bringup();
    bit ok;
    logic [2:0] prev, exp_v;
    exp_q.push_back(3'b001); exp_q.push_back(3'b011); exp_q.push_back(3'b111);
    prev = 3'b000;
    for (int s = 0; s < 3; s++) begin
      wait_ready_change(prev, ok);
      exp_v = exp_q.pop_front();
      total_cnt++; if (!ok || pll_ready !== exp_v) $display("FAIL bringup_ready_step%0d got=%b exp=%b", s, pll_ready, exp_v); else pass_cnt++;
      prev = pll_ready;
    end
    total_cnt++; if (all_ready !== 1'b1 || fault !== 1'b0) $display("FAIL bringup_final got=%b/%b exp=1/0", all_ready, fault); else pass_cnt++;
  endtask

  task automatic test_lock_loss();
    bit ok;
    logic [2:0] prev, exp_v;
    for (int it = 0; it < 300; it++) begin
      drop[1] = 1'b1;
      wait_all_ready(1'b0, ok);
      exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
      total_cnt++; if (!ok || loss_count !== 8'(exp_loss)) $display("FAIL loss_count_it%0d got=%0d exp=%0d", it, loss_count, exp_loss); else pass_cnt++;
      if (it == 0) begin
        total_cnt++; if (pll_ready !== 3'b001) $display("FAIL loss_pll_ready got=%b exp=001", pll_ready); else pass_cnt++;
        total_cnt++; if (pll_rst !== 3'b110) $display("FAIL loss_pll_rst got=%b exp=110", pll_rst); else pass_cnt++;
        exp_q.push_back(3'b011); exp_q.push_back(3'b111);
      end
      drop[1] = 1'b0;
      if (it == 0) begin
        prev = pll_ready;
        for (int s = 0; s < 2; s++) begin
          wait_ready_change(prev, ok);
          exp_v = exp_q.pop_front();
          total_cnt++; if (!ok || pll_ready !== exp_v) $display("FAIL loss_requal_step%0d got=%b exp=%b", s, pll_ready, exp_v); else pass_cnt++;
          prev = pll_ready;
        end
      end
      wait_all_ready(1'b1, ok);
      if (!ok) begin
        total_cnt++; $display("FAIL loss_requal_timeout_it%0d got=%b exp=1", it, all_ready);
      end
    end
    total_cnt++; if (loss_count !== 8'd255 || all_ready !== 1'b1) $display("FAIL loss_saturate got=%0d/%b exp=255/1", loss_count, all_ready); else pass_cnt++;
  endtask

  task automatic test_stable_glitch();
    int n;
    bit ok;
    glitch[0] = 1'b1;
    pulse_restart();
    total_cnt++; if (pll_ready !== 3'b000 || pll_rst !== 3'b111) $display("FAIL glitch_restart got=%b/%b exp=000/111", pll_ready, pll_rst); else pass_cnt++;
    run_length(0, 1'b1, n);
    total_cnt++; if (n != 4) $display("FAIL glitch_first_pulse got=%0d exp=4", n); else pass_cnt++;
    wait_rst_level(0, 1'b1, ok);
    glitch[0] = 1'b0;
    total_cnt++; if (!ok) $display("FAIL glitch_repulse_seen got=%b exp=1", pll_rst[0]); else pass_cnt++;
    run_length(0, 1'b1, n);
    total_cnt++; if (n != 4 || pll_ready !== 3'b000) $display("FAIL glitch_repulse got=%0d/%b exp=4/000", n, pll_ready); else pass_cnt++;
    wait_all_ready(1'b1, ok);
    total_cnt++; if (!ok || pll_ready !== 3'b111 || fault !== 1'b0) $display("FAIL glitch_complete got=%b/%b exp=111/0", pll_ready, fault); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int n;
    bit ok;
    stuck[1] = 1'b1;
    pulse_restart();
    wait_ready_change(3'b000, ok);
    total_cnt++; if (!ok || pll_ready !== 3'b001) $display("FAIL timeout_pll0_ready got=%b exp=001", pll_ready); else pass_cnt++;
    run_length(1, 1'b1, n);
    total_cnt++; if (n != 4) $display("FAIL timeout_pll1_pulse1 got=%0d exp=4", n); else pass_cnt++;
    run_length(1, 1'b0, n);
    total_cnt++; if (n != 20) $display("FAIL timeout_wait1 got=%0d exp=20", n); else pass_cnt++;
    run_length(1, 1'b1, n);
    total_cnt++; if (n != 4) $display("FAIL timeout_pll1_pulse2 got=%0d exp=4", n); else pass_cnt++;
    run_length(1, 1'b0, n);
    total_cnt++; if (n != 20) $display("FAIL timeout_wait2 got=%0d exp=20", n); else pass_cnt++;
    total_cnt++; if (fault !== 1'b1 || fault_idx !== 2'd1) $display("FAIL timeout_fault got=%b/%0d exp=1/1", fault, fault_idx); else pass_cnt++;
    total_cnt++; if (pll_ready !== 3'b001 || pll_rst !== 3'b110 || all_ready !== 1'b0) $display("FAIL timeout_outputs got=%b/%b/%b exp=001/110/0", pll_ready, pll_rst, all_ready); else pass_cnt++;
    repeat (30) @(negedge clk);
    total_cnt++; if (fault !== 1'b1 || pll_rst !== 3'b110) $display("FAIL timeout_terminal got=%b/%b exp=1/110", fault, pll_rst); else pass_cnt++;
  endtask

  task automatic test_restart_from_fault();
    int n;
    bit ok;
    stuck[1] = 1'b0;
    pulse_restart();
    total_cnt++; if (fault !== 1'b0 || fault_idx !== 2'd0) $display("FAIL restart_fault got=%b/%0d exp=0/0", fault, fault_idx); else pass_cnt++;
    total_cnt++; if (pll_ready !== 3'b000 || pll_rst !== 3'b111) $display("FAIL restart_outputs got=%b/%b exp=000/111", pll_ready, pll_rst); else pass_cnt++;
    total_cnt++; if (loss_count !== 8'd255) $display("FAIL restart_loss_kept got=%0d exp=255", loss_count); else pass_cnt++;
    run_length(0, 1'b1, n);
    total_cnt++; if (n != 4) $display("FAIL restart_pll0_pulse got=%0d exp=4", n); else pass_cnt++;
    wait_all_ready(1'b1, ok);
    total_cnt++; if (!ok || pll_ready !== 3'b111) $display("FAIL restart_complete got=%b exp=111", pll_ready); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int n;
    bit ok;
    pulse_restart();
    wait_ready_change(3'b000, ok);
    run_length(1, 1'b1, n);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (pll_rst !== 3'b111 || pll_ready !== 3'b000) $display("FAIL async_outputs got=%b/%b exp=111/000", pll_rst, pll_ready); else pass_cnt++;
    total_cnt++; if (loss_count !== 8'd0 || all_ready !== 1'b0 || fault !== 1'b0) $display("FAIL async_status got=%0d/%b/%b exp=0/0/0", loss_count, all_ready, fault); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    run_length(0, 1'b1, n);
    total_cnt++; if (n != 4) $display("FAIL async_pll0_pulse got=%0d exp=4", n); else pass_cnt++;
    wait_all_ready(1'b1, ok);
    total_cnt++; if (!ok || pll_ready !== 3'b111) $display("FAIL async_requal got=%b exp=111", pll_ready); else pass_cnt++;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_normal_bringup();
    test_lock_loss();
    test_stable_glitch();
    test_timeout();
    test_restart_from_fault();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
